cmd_router: RTL

Parametrised successor to the two-channel command decoder in the eth path. It takes address-mapped host commands (addr/data/level write strobe) and routes register writes to NUM_CH register-port channels. Each channel has its own small FIFO with valid/ready handshake, so a slow VRC consumer no longer loses writes. Control-space commands produce per-channel command pulses and a global FIFO flush; dropped writes are counted.

---
 rtl/cmd_router_pkg.sv | 18 +
 rtl/cmd_fifo.sv | 74 +++++++
 rtl/cmd_router.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/cmd_router_pkg.sv
// Shared constants and helpers for the command router and its channel FIFOs.
package cmd_router_pkg;

  // Channel-select value that never targets anything.
  localparam int unsigned SEL_IGNORE = 0;

  // Control-space opcode that empties every channel FIFO and clears the drop count.
  localparam logic [7:0] CMD_FLUSH = 8'hFF;

  // Width of the saturating dropped-write counter.
  localparam int unsigned DROP_CNT_W = 16;

  // All-ones select value that addresses control space.
  function automatic int unsigned sel_ctrl(input int unsigned sel_w);
    return (32'd1 << sel_w) - 32'd1;
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous show-ahead FIFO. The head entry is visible whenever the FIFO is
// non-empty; the output reads as zero while empty. Flush wins over push and pop.
module cmd_fifo
  import cmd_router_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_flush,
  input  logic             i_wr,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_full,
  output logic             o_empty,
  input  logic             i_rd,
  output logic [WIDTH-1:0] o_data
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wr_en;
  logic             rd_en;

  assign o_full  = (cnt_q == CNT_W'(DEPTH));
  assign o_empty = (cnt_q == '0);
  assign wr_en   = i_wr & ~o_full & ~i_flush;
  assign rd_en   = i_rd & ~o_empty & ~i_flush;
  assign o_data  = o_empty ? '0 : mem_q[rd_ptr_q];

  // Pointer and occupancy next-state; DEPTH is a power of two so pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (rd_en) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      unique case ({wr_en, rd_en})
        2'b10:   cnt_d = cnt_q + CNT_W'(1);
        2'b01:   cnt_d = cnt_q - CNT_W'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Pointer and occupancy state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage; contents need no reset because the output is masked while empty.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= i_data;
  end

endmodule

// File: rtl/cmd_router.sv
// Routes edge-triggered host commands to per-channel register FIFOs, issues
// per-channel control pulses and a global flush, and counts dropped writes.
module cmd_router
  import cmd_router_pkg::*;
#(
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned SEL_LSB    = 8,
  parameter int unsigned SEL_W      = 2,
  parameter int unsigned REG_AW     = 8,
  parameter int unsigned REG_DW     = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [ADDR_W-1:0]        i_cmd_addr,
  input  logic [DATA_W-1:0]        i_cmd_data,
  input  logic                     i_cmd_wren,
  output logic [NUM_CH*REG_AW-1:0] o_reg_addr,
  output logic [NUM_CH*REG_DW-1:0] o_reg_data,
  output logic [NUM_CH-1:0]        o_reg_valid,
  input  logic [NUM_CH-1:0]        i_reg_ready,
  output logic [NUM_CH-1:0]        o_ch_cmd,
  output logic [DATA_W-1:0]        o_ch_cmd_data,
  output logic [DROP_CNT_W-1:0]    o_drop_cnt
);

  localparam int unsigned  ENTRY_W  = REG_AW + REG_DW;
  localparam logic [SEL_W-1:0] SelCtrl = SEL_W'(sel_ctrl(SEL_W));
  localparam logic [SEL_W-1:0] SelIgn  = SEL_W'(SEL_IGNORE);

  logic                  wren_q;
  logic                  fire;
  logic [SEL_W-1:0]      sel;
  logic [7:0]            op;
  logic                  reg_fire;
  logic                  ctrl_fire;
  logic                  flush;
  logic                  drop;
  logic [NUM_CH-1:0]     push;
  logic [NUM_CH-1:0]     drop_ch;
  logic [NUM_CH-1:0]     full;
  logic [NUM_CH-1:0]     empty;
  logic [NUM_CH-1:0]     ch_cmd_q, ch_cmd_d;
  logic [DATA_W-1:0]     ch_cmd_data_q, ch_cmd_data_d;
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [ENTRY_W-1:0]    wr_entry;
  logic                  unused_addr;

  // Only the select field and the low byte carry meaning.
  assign unused_addr = ^i_cmd_addr;

  assign fire      = i_cmd_wren & ~wren_q;
  assign sel       = i_cmd_addr[SEL_LSB +: SEL_W];
  assign op        = i_cmd_addr[7:0];
  assign reg_fire  = fire && (sel != SelIgn) && (sel != SelCtrl);
  assign ctrl_fire = fire && (sel == SelCtrl);
  assign flush     = ctrl_fire && (op == CMD_FLUSH);
  assign drop      = |drop_ch;
  assign wr_entry  = {i_cmd_addr[REG_AW-1:0], i_cmd_data[REG_DW-1:0]};

  // Per-channel write steering and control-pulse decode.
  always_comb begin
    push     = '0;
    drop_ch  = '0;
    ch_cmd_d = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      // Fullness is sampled before the edge, so a same-cycle pop cannot rescue a write.
      if (reg_fire && (sel == SEL_W'(k + 1))) begin
        push[k]    = ~full[k];
        drop_ch[k] = full[k];
      end
      ch_cmd_d[k] = ctrl_fire && (op == 8'(k));
    end
  end

  // Control data is latched only for opcodes that actually pulse a channel.
  always_comb begin
    ch_cmd_data_d = ch_cmd_data_q;
    if (ctrl_fire && (32'(op) < NUM_CH)) ch_cmd_data_d = i_cmd_data;
  end

  // Saturating drop counter, cleared by flush.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (flush) begin
      drop_cnt_d = '0;
    end else if (drop && (drop_cnt_q != '1)) begin
      drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
    end
  end

  // Edge detect, control outputs and drop counter. The edge detector resets
  // high so a strobe held across reset release needs a fresh rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wren_q        <= 1'b1;
      ch_cmd_q      <= '0;
      ch_cmd_data_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      wren_q        <= i_cmd_wren;
      ch_cmd_q      <= ch_cmd_d;
      ch_cmd_data_q <= ch_cmd_data_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : gen_ch
    logic [ENTRY_W-1:0] head;

    cmd_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_flush (flush),
      .i_wr    (push[k]),
      .i_data  (wr_entry),
      .o_full  (full[k]),
      .o_empty (empty[k]),
      .i_rd    (i_reg_ready[k]),
      .o_data  (head)
    );

    assign o_reg_valid[k]                 = ~empty[k];
    assign o_reg_addr[k*REG_AW +: REG_AW] = head[ENTRY_W-1 -: REG_AW];
    assign o_reg_data[k*REG_DW +: REG_DW] = head[REG_DW-1:0];
  end

  assign o_ch_cmd      = ch_cmd_q;
  assign o_ch_cmd_data = ch_cmd_data_q;
  assign o_drop_cnt    = drop_cnt_q;

`ifndef SYNTHESIS
  // At most one channel pulses per control command.
  a_ch_cmd_onehot : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(o_ch_cmd));
`endif

endmodule
